// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Multi-cycle binary-to-BCD converter (shift-and-add-3 / double dabble).
// Converts one IN_W-bit unsigned value per request, one bit per clock, and
// publishes DIGITS BCD nibbles. Inputs that do not fit in DIGITS decimal
// digits saturate to all nines and raise ovf. An optional leading-zero mask
// tells the 7-segment driver which digits to leave dark.
//
// Parameters
//   IN_W     binary input width (>= 4)
//   DIGITS   BCD digits published (>= 1)
//   BLANK_LZ 1 = drive the leading-zero blank mask, 0 = blank tied low
//
// Ports
//   clk     system clock, rising edge
//   rst     synchronous reset, active high (aborts a conversion in flight)
//   start   conversion request, only looked at while idle
//   in      binary value, captured when start is accepted
//   busy    conversion in progress, up to and including the done cycle
//   done    one-cycle pulse, digits/blank/ovf updated
//   digits  BCD result, digit k at [4k+3:4k], k=0 is the ones digit
//   blank   bit k set = digit k is a leading zero (bit 0 never set)
//   ovf     input exceeded 10^DIGITS-1, digits saturated to all nines
// ---------------------------------------------------------------------------

// Per-nibble correction: a digit of 5 or more would exceed 9 after the next
// doubling, so pre-add 3 to carry it into the next nibble on the shift.
module bin_to_bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
    parameter int IN_W     = 14,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf
);

    // Scratch nibbles: enough to hold any IN_W-bit value in decimal
    // (IN_W*log10(2) < IN_W/3), never fewer than the published digits. This
    // keeps overflowing inputs from wrapping inside the reduction.
    localparam int NEED_NIB = (IN_W + 2) / 3;
    localparam int SN       = (DIGITS > NEED_NIB) ? DIGITS : NEED_NIB;
    localparam int SW       = 4 * SN;
    localparam int CW       = $clog2(IN_W);
    // Limit arithmetic width: 10x a value capped at 2^IN_W fits in IN_W+4 bits.
    localparam int LW       = IN_W + 5;

    // 10^DIGITS, clamped to 2^IN_W so huge digit counts cannot overflow the
    // constant. A clamp of 2^IN_W can never be reached by an IN_W-bit input,
    // which is exactly the "never overflows" answer.
    function automatic logic [LW-1:0] calc_limit(input int nd);
        logic [LW-1:0] p;
        logic [LW-1:0] cap;
        p        = LW'(1);
        cap      = '0;
        cap[IN_W] = 1'b1;
        for (int i = 0; i < nd; i++) begin
            p = p * LW'(10);
            if (p > cap) p = cap;
        end
        return p;
    endfunction

    localparam logic [LW-1:0]     LIMIT     = calc_limit(DIGITS);
    localparam logic [DIGITS-1:0] BLANK_RST = (BLANK_LZ != 0) ? ~DIGITS'(1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IN_W-1:0]     bin_q;
    logic [SW-1:0]       scr_q;
    logic [CW-1:0]       cnt_q;
    logic                ovfp_q;
    logic                done_q;
    logic [4*DIGITS-1:0] digits_q;
    logic [DIGITS-1:0]   blank_q;
    logic                ovf_q;

    logic                accept;
    logic                last_bit;
    logic [SW-1:0]       scr_adj;
    logic [SW+IN_W-1:0]  shifted;
    logic [4*DIGITS-1:0] digits_d;
    logic [DIGITS-1:0]   blank_d;
    logic                allz;

    // A start seen in the done cycle is dropped: the FSM is already back in
    // IDLE there, but the conversion is not finished from the caller's view.
    assign accept   = (state_q == S_IDLE) && start && !done_q;
    assign last_bit = (cnt_q == CW'(IN_W - 1));

    // ---------------------------------------------------------------------
    // Add-3 correction on every scratch nibble, then shift the combined
    // {scratch, binary} register left so the binary MSB enters scratch LSB.
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < SN; g++) begin : g_nib
        bin_to_bcd_add3 u_add3 (
            .d (scr_q[4*g +: 4]),
            .q (scr_adj[4*g +: 4])
        );
    end

    assign shifted = {scr_adj, bin_q} << 1;

    // ---------------------------------------------------------------------
    // Result formatting (valid while in DONE)
    // ---------------------------------------------------------------------
    always_comb begin
        digits_d = ovfp_q ? {DIGITS{4'h9}} : scr_q[4*DIGITS-1:0];
        blank_d  = '0;
        allz     = 1'b1;
        if (BLANK_LZ != 0 && !ovfp_q) begin
            // Walk down from the top digit; a digit is blank only while every
            // digit above it (and itself) is zero. Digit 0 is always shown.
            for (int k = DIGITS - 1; k >= 1; k--) begin
                allz       = allz & (digits_d[4*k +: 4] == 4'h0);
                blank_d[k] = allz;
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept)   state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:                state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            scr_q    <= '0;
            cnt_q    <= '0;
            ovfp_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
            blank_q  <= BLANK_RST;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        bin_q  <= in;
                        scr_q  <= '0;
                        cnt_q  <= '0;
                        ovfp_q <= ({{(LW-IN_W){1'b0}}, in} >= LIMIT);
                    end
                end
                S_SHIFT: begin
                    {scr_q, bin_q} <= shifted;
                    cnt_q          <= cnt_q + CW'(1);
                end
                S_DONE: begin
                    digits_q <= digits_d;
                    blank_q  <= blank_d;
                    ovf_q    <= ovfp_q;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE) || done_q;
    assign done   = done_q;
    assign digits = digits_q;
    assign blank  = blank_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq. Three instances:
//   u_a default (14 bit, 4 digits, blanking), u_b 7 bit / 2 digits,
//   u_c default widths with blanking disabled.
// Drivers push the expected result when a start is issued; per-instance
// monitors pop and compare whenever done is seen.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  b;
        logic        o;
        logic [31:0] acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // instance A
    logic        rst_a, start_a, busy_a, done_a, ovf_a;
    logic [13:0] in_a;
    logic [15:0] dig_a;
    logic [3:0]  blk_a;
    // instance B
    logic        rst_b, start_b, busy_b, done_b, ovf_b;
    logic [6:0]  in_b;
    logic [7:0]  dig_b;
    logic [1:0]  blk_b;
    // instance C
    logic        rst_c, start_c, busy_c, done_c, ovf_c;
    logic [13:0] in_c;
    logic [15:0] dig_c;
    logic [3:0]  blk_c;

    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;

    bin_to_bcd_seq u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .in(in_a), .busy(busy_a),
        .done(done_a), .digits(dig_a), .blank(blk_a), .ovf(ovf_a)
    );

    bin_to_bcd_seq #(.IN_W(7), .DIGITS(2), .BLANK_LZ(1)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .in(in_b), .busy(busy_b),
        .done(done_b), .digits(dig_b), .blank(blk_b), .ovf(ovf_b)
    );

    bin_to_bcd_seq #(.IN_W(14), .DIGITS(4), .BLANK_LZ(0)) u_c (
        .clk(clk), .rst(rst_c), .start(start_c), .in(in_c), .busy(busy_c),
        .done(done_c), .digits(dig_c), .blank(blk_c), .ovf(ovf_c)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got done with digits %0h expected no done (t=%0t)", nm, act, $time);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (qa.size() == 0) unexpected("a_extra_done", 32'(dig_a));
            else begin
                ea = qa.pop_front();
                chk("a_digits", 32'(dig_a), 32'(ea.d));
                chk("a_blank", 32'(blk_a), 32'(ea.b));
                chk("a_ovf", 32'(ovf_a), 32'(ea.o));
                chk("a_latency", 32'(cyc) - ea.acc, 32'd15);
                chk("a_busy_in_done", 32'(busy_a), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (done_b === 1'b1) begin
            if (qb.size() == 0) unexpected("b_extra_done", 32'(dig_b));
            else begin
                eb = qb.pop_front();
                chk("b_digits", 32'(dig_b), 32'(eb.d));
                chk("b_blank", 32'(blk_b), 32'(eb.b));
                chk("b_ovf", 32'(ovf_b), 32'(eb.o));
                chk("b_latency", 32'(cyc) - eb.acc, 32'd8);
            end
        end
    end

    always @(negedge clk) begin
        if (done_c === 1'b1) begin
            if (qc.size() == 0) unexpected("c_extra_done", 32'(dig_c));
            else begin
                ec = qc.pop_front();
                chk("c_digits", 32'(dig_c), 32'(ec.d));
                chk("c_blank", 32'(blk_c), 32'(ec.b));
                chk("c_ovf", 32'(ovf_c), 32'(ec.o));
                chk("c_latency", 32'(cyc) - ec.acc, 32'd15);
            end
        end
    end

    // ---------------- drivers ----------------
    // All drivers are entered #1 after a rising edge; start is sampled at the
    // next edge, and the expectation records that edge's number.
    task automatic go_a(input logic [13:0] v, input bit push, input logic [15:0] ed,
                        input logic [3:0] ebl, input logic eo);
        exp_t e;
        in_a = v; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        e = '{d: ed, b: ebl, o: eo, acc: 32'(cyc)};
        if (push) qa.push_back(e);
    endtask

    task automatic go_b(input logic [6:0] v, input logic [7:0] ed,
                        input logic [1:0] ebl, input logic eo);
        exp_t e;
        in_b = v; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        e = '{d: {8'h00, ed}, b: {2'b00, ebl}, o: eo, acc: 32'(cyc)};
        qb.push_back(e);
    endtask

    task automatic go_c(input logic [13:0] v, input logic [15:0] ed,
                        input logic [3:0] ebl, input logic eo);
        exp_t e;
        in_c = v; start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        e = '{d: ed, b: ebl, o: eo, acc: 32'(cyc)};
        qc.push_back(e);
    endtask

    // Returns #1 into the done cycle, or flags a timeout.
    task automatic wait_done(input int w);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk); #1;
            if ((w == 0 && done_a === 1'b1) || (w == 1 && done_b === 1'b1) ||
                (w == 2 && done_c === 1'b1)) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout_%0d: got no done expected done within 200 cycles", w);
        end
    endtask

    task automatic finish_a();
        wait_done(0);
        @(posedge clk); #1;
        chk("a_busy_after_done", 32'(busy_a), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        chk("a_rst_digits", 32'(dig_a), 32'h0);
        chk("a_rst_blank", 32'(blk_a), 32'b1110);
        chk("a_rst_ovf", 32'(ovf_a), 32'd0);
        chk("a_rst_busy", 32'(busy_a), 32'd0);
        chk("a_rst_done", 32'(done_a), 32'd0);
        chk("b_rst_blank", 32'(blk_b), 32'b10);
        chk("c_rst_blank", 32'(blk_c), 32'b0000);

        fork
            begin : seq_a
                go_a(14'd0, 1, 16'h0000, 4'b1110, 1'b0);     finish_a();
                go_a(14'd9999, 1, 16'h9999, 4'b0000, 1'b0);  finish_a();
                go_a(14'd405, 1, 16'h0405, 4'b1000, 1'b0);   finish_a();
                go_a(14'd16383, 1, 16'h9999, 4'b0000, 1'b1); finish_a();

                // busy-time starts are dropped; in changes are ignored
                go_a(14'd1234, 1, 16'h1234, 4'b0000, 1'b0);  // busy cycle 1
                repeat (2) begin @(posedge clk); #1; end     // cycle 3
                in_a = 14'd42; start_a = 1'b1;
                @(posedge clk); #1; start_a = 1'b0;
                repeat (6) begin @(posedge clk); #1; end     // cycle 10
                start_a = 1'b1;
                @(posedge clk); #1; start_a = 1'b0;
                wait_done(0);                                // done cycle
                start_a = 1'b1;
                @(posedge clk); #1; start_a = 1'b0;
                chk("a_busy_after_done", 32'(busy_a), 32'd0);
                go_a(14'd42, 1, 16'h0042, 4'b1100, 1'b0);    finish_a();

                // reset in SHIFT cycle 7 aborts without a done pulse
                go_a(14'd5000, 0, 16'h0, 4'b0, 1'b0);
                repeat (6) begin @(posedge clk); #1; end
                rst_a = 1'b1;
                @(posedge clk); #1; rst_a = 1'b0;
                chk("a_abort_digits", 32'(dig_a), 32'h0);
                chk("a_abort_blank", 32'(blk_a), 32'b1110);
                chk("a_abort_ovf", 32'(ovf_a), 32'd0);
                chk("a_abort_busy", 32'(busy_a), 32'd0);
                repeat (20) begin @(posedge clk); #1; end
                chk("a_abort_no_done", 32'(qa.size()), 32'd0);
                go_a(14'd77, 1, 16'h0077, 4'b1100, 1'b0);    finish_a();
            end
            begin : seq_b
                for (int v = 0; v < 128; v++) begin
                    if (v <= 99)
                        go_b(7'(v), {4'(v / 10), 4'(v % 10)}, (v < 10) ? 2'b10 : 2'b00, 1'b0);
                    else
                        go_b(7'(v), 8'h99, 2'b00, 1'b1);
                    wait_done(1);
                    @(posedge clk); #1;
                end
            end
            begin : seq_c
                go_c(14'd7, 16'h0007, 4'b0000, 1'b0);
                wait_done(2);
                @(posedge clk); #1;
                go_c(14'd0, 16'h0000, 4'b0000, 1'b0);
                wait_done(2);
                @(posedge clk); #1;
            end
        join

        repeat (5) @(posedge clk);
        #1;
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        chk("c_queue_drained", 32'(qc.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
